// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: default widths, memory rw encoding and the loader state enum.
package mu0_pkg;

  localparam int MU0_DATA_W      = 16;
  localparam int MU0_ADDR_W      = 12;
  localparam int MU0_DEPTH       = 32;
  localparam int MU0_HOLD_CYCLES = 2;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [2:0] {
    LDR_IDLE  = 3'd0,
    LDR_LOAD  = 3'd1,
    LDR_DRAIN = 3'd2,
    LDR_HOLD  = 3'd3,
    LDR_RUN   = 3'd4
  } ldr_state_t;

endpackage

// File: rtl/mu0_bus_mux.sv
// Memory bus owner select: the loader drives the bus unless the MU0 core owns it.
module mu0_bus_mux
  import mu0_pkg::*;
#(
  parameter int DATA_W = MU0_DATA_W,
  parameter int ADDR_W = MU0_ADDR_W
) (
  input  logic              cpu_owns,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_data,
  input  logic              ldr_memrq,
  input  logic              ldr_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_memrq,
  input  logic              cpu_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_memrq,
  output logic              mem_rw
);

  always_comb begin
    if (cpu_owns) begin
      mem_addr    = cpu_addr;
      mem_in_data = cpu_out_data;
      mem_memrq   = cpu_memrq;
      mem_rw      = cpu_rnw;
    end else begin
      mem_addr    = ldr_addr;
      mem_in_data = ldr_data;
      mem_memrq   = ldr_memrq;
      mem_rw      = ldr_rw;
    end
  end

endmodule

// File: rtl/mu0_program_loader.sv
// MU0 boot loader: streams words into program memory, then releases the core after a hold time.
// Optional checksum check on the final word is enabled by defining MU0_LOADER_CHECKSUM_EN.
module mu0_program_loader
  import mu0_pkg::*;
#(
  parameter int DATA_W      = MU0_DATA_W,
  parameter int ADDR_W      = MU0_ADDR_W,
  parameter int DEPTH       = MU0_DEPTH,
  parameter int HOLD_CYCLES = MU0_HOLD_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              cpu_memrq,
  input  logic              cpu_rnw,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in_data,
  output logic              mem_memrq,
  output logic              mem_rw,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   load_count,
  output logic [DATA_W-1:0] ld_sum,
  input  logic [DATA_W-1:0] ld_expected
);

  localparam int                HC_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'(HOLD_CYCLES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  ldr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              err_q, err_d;
  logic              ld_ready_q, busy_q, cpu_rst_q;
  logic              hs, wr_en, base_bad, sum_fault;
  logic [DATA_W-1:0] sum_q, sum_d, sum_add;

  assign hs       = ld_valid & ld_ready_q;
  assign base_bad = ({1'b0, ld_base} >= DEPTH_X);
  assign sum_add  = sum_q + ld_data;

`ifdef MU0_LOADER_CHECKSUM_EN
  assign sum_fault = (sum_add != ld_expected);
  assign ld_sum    = sum_q;
`else
  logic unused_expected;
  assign unused_expected = ^ld_expected;
  assign sum_fault = 1'b0;
  assign ld_sum    = '0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sum_d   = sum_q;
    hold_d  = '0;
    wr_en   = 1'b0;
    unique case (state_q)
      LDR_IDLE, LDR_RUN: begin
        if (ld_start) begin
          cnt_d = '0;
          sum_d = '0;
          if (base_bad) begin
            err_d   = 1'b1;
            ptr_d   = '0;
            state_d = LDR_DRAIN;
          end else begin
            err_d   = 1'b0;
            ptr_d   = ld_base;
            state_d = LDR_LOAD;
          end
        end
      end
      LDR_LOAD: begin
        if (hs) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_add;
          if (ptr_q != LAST_ADDR) ptr_d = ptr_q + 1'b1;
          // The last word wins over overflow: a program that exactly fills memory is valid.
          if (ld_last) begin
            if (sum_fault) begin
              err_d   = 1'b1;
              state_d = LDR_IDLE;
            end else begin
              state_d = LDR_HOLD;
            end
          end else if (ptr_q == LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = LDR_DRAIN;
          end
        end
      end
      LDR_DRAIN: begin
        if (hs && ld_last) state_d = LDR_IDLE;
      end
      LDR_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = LDR_RUN;
        else hold_d = hold_q + 1'b1;
      end
      default: state_d = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LDR_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
      sum_q      <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      err_q      <= err_d;
      sum_q      <= sum_d;
      // Outputs are registered from the next state so they change with the state itself.
      ld_ready_q <= (state_d == LDR_LOAD) || (state_d == LDR_DRAIN);
      busy_q     <= (state_d == LDR_LOAD) || (state_d == LDR_DRAIN) || (state_d == LDR_HOLD);
      cpu_rst_q  <= (state_d == LDR_RUN);
    end
  end

  assign ld_ready   = ld_ready_q;
  assign busy       = busy_q;
  assign cpu_rst_n  = cpu_rst_q;
  assign error      = err_q;
  assign load_count = cnt_q;

  mu0_bus_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bus_mux (
    .cpu_owns    (cpu_rst_q),
    .ldr_addr    (ptr_q),
    .ldr_data    (ld_data),
    .ldr_memrq   (wr_en),
    .ldr_rw      (wr_en ? MEM_WRITE : MEM_READ),
    .cpu_addr    (cpu_addr),
    .cpu_out_data(cpu_out_data),
    .cpu_memrq   (cpu_memrq),
    .cpu_rnw     (cpu_rnw),
    .mem_addr    (mem_addr),
    .mem_in_data (mem_in_data),
    .mem_memrq   (mem_memrq),
    .mem_rw      (mem_rw)
  );

endmodule

// File: tb/tb_mu0_program_loader.sv
// Directed bench for mu0_program_loader with a behavioural program memory on the bus.
module tb_mu0_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_start;
  logic [11:0] ld_base;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        ld_last;
  logic [11:0] cpu_addr;
  logic [15:0] cpu_out_data;
  logic        cpu_memrq;
  logic        cpu_rnw;
  logic        cpu_rst_n;
  logic [11:0] mem_addr;
  logic [15:0] mem_in_data;
  logic        mem_memrq;
  logic        mem_rw;
  logic        busy;
  logic        error;
  logic [12:0] load_count;
  logic [15:0] ld_sum;
  logic [15:0] ld_expected;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_memrq && mem_rw == 1'b0) mem[mem_addr] <= mem_in_data;

  mu0_program_loader dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_base(ld_base),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .cpu_addr(cpu_addr), .cpu_out_data(cpu_out_data), .cpu_memrq(cpu_memrq),
    .cpu_rnw(cpu_rnw), .cpu_rst_n(cpu_rst_n), .mem_addr(mem_addr),
    .mem_in_data(mem_in_data), .mem_memrq(mem_memrq), .mem_rw(mem_rw),
    .busy(busy), .error(error), .load_count(load_count), .ld_sum(ld_sum),
    .ld_expected(ld_expected)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] prog_word(input int i);
    return 16'hA000 ^ 16'(i * 16'h0111);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; cpu_addr = '0; cpu_out_data = '0; cpu_memrq = 1'b0;
    cpu_rnw = 1'b1; ld_expected = '0;
    step(); step();
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_load_count", load_count, 0);
    check("rst_ld_sum", ld_sum, 0);
    check("rst_mem_memrq", mem_memrq, 0);
    check("rst_mem_rw", mem_rw, 1);
    rst_n = 1'b1;
    step();
    check("idle_ready", ld_ready, 0);

    // Sum program: 21 words at base 0, continuous valid
    ld_start = 1'b1; ld_base = 12'd0;
    #1 check("ready_before_edge", ld_ready, 0);
    step();
    ld_start = 1'b0;
    check("ready_after_start", ld_ready, 1);
    check("busy_load", busy, 1);
    for (int i = 0; i < 21; i++) begin
      ld_valid = 1'b1; ld_data = prog_word(i); ld_last = (i == 20);
      if (i == 0) begin
        #1;
        check("first_memrq", mem_memrq, 1);
        check("first_rw", mem_rw, 0);
        check("first_addr", mem_addr, 0);
      end
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("sum_load_count", load_count, 21);
    check("hold_n0_cpu_rst", cpu_rst_n, 0);
    check("hold_busy", busy, 1);
    check("hold_ready", ld_ready, 0);
    step(); check("hold_n1_cpu_rst", cpu_rst_n, 0);
    step(); check("hold_n2_cpu_rst", cpu_rst_n, 0);
    step(); check("run_n3_cpu_rst", cpu_rst_n, 1);
    check("run_busy", busy, 0);
    check("run_error", error, 0);
    for (int i = 0; i < 21; i++) check($sformatf("sum_mem[%0d]", i), mem[i], prog_word(i));

    // RUN pass-through
    cpu_addr = 12'h005; cpu_out_data = 16'hBEEF; cpu_memrq = 1'b1; cpu_rnw = 1'b1;
    #1;
    check("run_mem_addr", mem_addr, 12'h005);
    check("run_mem_memrq", mem_memrq, 1);
    check("run_mem_rw", mem_rw, 1);
    check("run_mem_data", mem_in_data, 16'hBEEF);
    check("run_ld_ready", ld_ready, 0);

    // Reload while the CPU is fetching, stream with gaps at base 24
    ld_start = 1'b1; ld_base = 12'd24;
    #1 check("reload_cpu_still_run", cpu_rst_n, 1);
    step();
    ld_start = 1'b0;
    check("reload_cpu_rst", cpu_rst_n, 0);
    check("reload_ready", ld_ready, 1);
    check("reload_bus_addr", mem_addr, 24);
    check("reload_bus_memrq", mem_memrq, 0);
    check("reload_bus_rw", mem_rw, 1);
    check("reload_count_clr", load_count, 0);
    for (int k = 0; k < 7; k++) begin
      ld_valid = (k % 2 == 0);
      ld_data  = ld_valid ? 16'(16'h5000 + k / 2) : 16'hDEAD;
      ld_last  = (k == 6);
      #1;
      if (!ld_valid) check($sformatf("gap_memrq_%0d", k), mem_memrq, 0);
      else check($sformatf("gap_addr_%0d", k), mem_addr, 24 + k / 2);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("gap_load_count", load_count, 4);
    step(); step(); step();
    check("gap_run", cpu_rst_n, 1);
    for (int i = 0; i < 4; i++) check($sformatf("gap_mem[%0d]", 24 + i), mem[24 + i], 16'h5000 + i);
    check("gap_mem28_untouched", mem[28], 16'hxxxx);

    // Out-of-range base goes straight to DRAIN
    ld_start = 1'b1; ld_base = 12'd40;
    step();
    ld_start = 1'b0;
    check("badbase_error", error, 1);
    check("badbase_ready", ld_ready, 1);
    check("badbase_cpu_rst", cpu_rst_n, 0);
    ld_valid = 1'b1; ld_data = 16'h1234; ld_last = 1'b1;
    #1 check("badbase_no_write", mem_memrq, 0);
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    check("badbase_idle_busy", busy, 0);
    check("badbase_error_held", error, 1);

    // Overflow: base 30, 5 words, DEPTH 32
    ld_start = 1'b1; ld_base = 12'd30;
    step();
    ld_start = 1'b0;
    check("ovf_error_cleared", error, 0);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'h7000 + i); ld_last = (i == 4);
      #1;
      if (i == 2) check("ovf_drain_no_write", mem_memrq, 0);
      step();
      if (i == 1) begin
        check("ovf_error_set", error, 1);
        check("ovf_drain_ready", ld_ready, 1);
        check("ovf_drain_busy", busy, 1);
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ovf_idle_busy", busy, 0);
    check("ovf_idle_ready", ld_ready, 0);
    check("ovf_error_held", error, 1);
    check("ovf_load_count", load_count, 2);
    check("ovf_mem30", mem[30], 16'h7000);
    check("ovf_mem31", mem[31], 16'h7001);
    check("ovf_mem32_untouched", mem[32], 16'hxxxx);
    step(); step(); step(); step();
    check("ovf_cpu_stays_reset", cpu_rst_n, 0);

    // Asynchronous reset after 4 words
    ld_start = 1'b1; ld_base = 12'd0;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'h9000 + i); ld_last = 1'b0;
      step();
    end
    ld_data = 16'h9004;
    rst_n = 1'b0;
    #1;
    check("arst_ready", ld_ready, 0);
    check("arst_cpu_rst", cpu_rst_n, 0);
    check("arst_load_count", load_count, 0);
    check("arst_busy", busy, 0);
    check("arst_error", error, 0);
    check("arst_memrq", mem_memrq, 0);
    step();
    ld_valid = 1'b0;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) check($sformatf("arst_mem[%0d]", i), mem[i], 16'h9000 + i);
    check("arst_mem4_kept", mem[4], prog_word(4));
    ld_start = 1'b1; ld_base = 12'd0;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'hC000 + i); ld_last = (i == 2);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("restart_count", load_count, 3);
    step(); step(); step();
    check("restart_run", cpu_rst_n, 1);
    for (int i = 0; i < 3; i++) check($sformatf("restart_mem[%0d]", i), mem[i], 16'hC000 + i);
    check("restart_mem3", mem[3], 16'h9003);

    // Checksum: words 1,2,3 against 7, then against 6
    ld_expected = 16'd7;
    ld_start = 1'b1; ld_base = 12'd0;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'(i + 1); ld_last = (i == 2);
      step();
      if (i == 1) begin
`ifdef MU0_LOADER_CHECKSUM_EN
        check("cks_partial_sum", ld_sum, 3);
`else
        check("cks_sum_tied", ld_sum, 0);
`endif
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
`ifdef MU0_LOADER_CHECKSUM_EN
    check("cks_bad_error", error, 1);
    check("cks_bad_idle", busy, 0);
    check("cks_bad_sum", ld_sum, 6);
    step(); step(); step();
    check("cks_bad_cpu_rst", cpu_rst_n, 0);
`else
    check("nocks_error", error, 0);
    check("nocks_hold", busy, 1);
    step(); step(); step();
    check("nocks_run", cpu_rst_n, 1);
`endif
    ld_expected = 16'd6;
    ld_start = 1'b1; ld_base = 12'd0;
    step();
    ld_start = 1'b0;
    check("cks2_error_cleared", error, 0);
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'(i + 1); ld_last = (i == 2);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("cks2_hold", busy, 1);
    step(); step(); step();
    check("cks2_run", cpu_rst_n, 1);
    check("cks2_error", error, 0);
`ifdef MU0_LOADER_CHECKSUM_EN
    check("cks2_sum", ld_sum, 6);
`else
    check("cks2_sum_tied", ld_sum, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
